gf_reduce: RTL

- Bit-serial modular reduction stage that sits directly downstream of the finite-field multiplier.
- Takes the unreduced (2*NUM_BITS-1)-bit carry-less product and reduces it modulo the field's irreducible polynomial to a NUM_BITS-bit field element.
- Uses a valid/ready handshake on both sides so the AES datapath can stall it.
- Fixed latency, one polynomial-bit eliminated per clock.

---
 rtl/gf_pkg.sv | 20 ++
 rtl/gf_reduce.sv | 92 +++++++++
 2 files changed

// File: rtl/gf_pkg.sv
// Shared constants and types for the GF(2^n) reduction stage.
// Default field is the AES field GF(2^8) with x^8+x^4+x^3+x+1.
package gf_pkg;

  localparam int GF_NUM_BITS = 8;
  localparam logic [8:0] AES_POLY = 9'h11B;

  function automatic int prod_width(input int num_bits);
    return 2 * num_bits - 1;
  endfunction

  localparam int GF_PROD_W = prod_width(GF_NUM_BITS);

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    DONE
  } state_t;

endpackage

// File: rtl/gf_reduce.sv
// Bit-serial reduction of a carry-less product modulo POLY.
// One high bit is eliminated per clock, always NUM_BITS-1 REDUCE cycles.
module gf_reduce
  import gf_pkg::*;
#(
  parameter int                NUM_BITS = GF_NUM_BITS,
  parameter logic [NUM_BITS:0] POLY     = AES_POLY
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*NUM_BITS-2:0] product,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NUM_BITS-1:0]   result
);

  localparam int PW = prod_width(NUM_BITS);
  localparam int IW = $clog2(PW);
  localparam logic [IW-1:0] IDX_TOP  = IW'(PW - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_BITS);
  localparam logic [PW-1:0] POLY_EXT = PW'(POLY);

  state_t              state_reg, state_next;
  logic [PW-1:0]       acc_reg, acc_next, acc_step;
  logic [IW-1:0]       idx_reg, idx_next;
  logic [NUM_BITS-1:0] result_reg, result_next;

  // Cancel bit idx by XORing in POLY aligned so its MSB lands on idx.
  always_comb begin
    acc_step = acc_reg;
    if (acc_reg[idx_reg]) begin
      acc_step = acc_reg ^ (POLY_EXT << (idx_reg - IDX_LAST));
    end
  end

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    idx_next    = idx_reg;
    result_next = result_reg;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_next   = product;
          idx_next   = IDX_TOP;
          state_next = REDUCE;
        end
      end
      REDUCE: begin
        acc_next = acc_step;
        idx_next = idx_reg - 1'b1;
        if (idx_reg == IDX_LAST) begin
          result_next = acc_step[NUM_BITS-1:0];
          idx_next    = '0;
          state_next  = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          // result must read 0 whenever out_valid is low
          result_next = '0;
          acc_next    = '0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      idx_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      idx_reg    <= idx_next;
      result_reg <= result_next;
    end
  end

  assign result = result_reg;

endmodule
